glitch_sequencer: RTL and testbench
===================================

// Module: glitch_sequencer
// PURPOSE
//  Sequences the glitch datapath from UART-configured parameters. Starts a run on a command
//  (pulse_en/reset_en) or on an external trigger edge once armed, optionally holds target reset,
//  waits a delay, then emits N glitch pulses of programmable width and spacing. Sits between
//  the UART command handler and the glitch/reset output pins.
// PARAMETERS
//  TRIG_SYNC_STAGES  2  synchronizer flops on trigger_i (>=2)
//  TRIG_RISING       1  1: trigger on trigger_i low->high; 0: high->low
// PORTS
//  clk              in   1   system clock
//  rst              in   1   synchronous, active-high reset
//  delay_i          in   16  cycles from start (or reset release) to first pulse
//  width_i          in   8   glitch pulse high time, cycles
//  num_pulses_i     in   8   pulses per run
//  pulse_spacing_i  in   16  low time between pulses, cycles
//  reset_length_i   in   16  target reset high time, cycles
//  pulse_en_i       in   1   1-cycle strobe: start run now
//  reset_en_i       in   1   1-cycle strobe: start run with target reset phase
//  arm_i            in   1   1-cycle strobe: arm (IDLE) / disarm (ARMED)
//  trigger_i        in   1   asynchronous external trigger
//  glitch_o         out  1   registered glitch pulse output
//  target_rst_o     out  1   registered target reset output
//  armed_o          out  1   high in ARMED
//  busy_o           out  1   high whenever state != IDLE
//  done_o           out  1   1-cycle strobe at end of run
// BEHAVIOUR
//  - Clock clk only; reset is synchronous, active-high. rst: state=IDLE; all outputs 0; counters 0.
//    rst mid-run forces glitch_o/target_rst_o low at the next edge.
//  - All outputs are flop outputs (no combinational path to glitch_o/target_rst_o).
//  - States: IDLE, ARMED, RESET, DELAY, PULSE, SPACE.
//  - IDLE: strobe priority reset_en_i > pulse_en_i > arm_i. On start, snapshot all five config
//    inputs; later input changes do not affect the run. reset_en_i with reset_length_i==0
//    behaves as pulse_en_i. arm_i -> ARMED.
//  - ARMED: synchronized trigger edge starts the run exactly as pulse_en_i would in that cycle.
//    A level already active at arm time does not trigger; a fresh edge is required.
//    arm_i -> IDLE (disarm). pulse_en_i/reset_en_i ignored.
//  - Strobes received in RESET/DELAY/PULSE/SPACE are ignored (not queued).
//  - Timing, with the start strobe sampled at edge t0:
//    RESET: target_rst_o high in cycles t0+1 .. t0+L (L = reset_length).
//    DELAY: glitch_o low for D cycles, starting the cycle after start or after reset release.
//    First glitch_o high at t0+1+D, or t0+1+L+D with a reset phase.
//    PULSE: glitch_o high for W cycles. SPACE: glitch_o low for S cycles between pulses.
//    S==0: pulses abut and glitch_o stays continuously high.
//    done_o is asserted in the cycle after the last high cycle; same edge -> IDLE.
//  - W==0 or N==0: DELAY still runs; no pulse; done_o in the cycle the first pulse would start.
//  - Trigger: high sampled at edge E0 -> edge event at E0+TRIG_SYNC_STAGES; that cycle is t0.
//  - Widths: 16-bit delay/spacing/reset down-counters, 8-bit width and pulse counters.
//    No wrap; max values (0xFFFF, 0xFF) are exact.
// STRUCTURE
//  - glitcher_pkg: state encodings; DELAY_W=16, WIDTH_W=8, NPULSE_W=8, SPACING_W=16, RSTLEN_W=16.
//  - Sub-module sync_edge_detect: TRIG_SYNC_STAGES-flop synchronizer + 1-cycle edge pulse,
//    polarity set by TRIG_RISING; reset clears all flops to the inactive level.
//  - Remaining logic (FSM, snapshot registers, counters) stays in this module.
// TESTING
//  1. D=3,W=2,N=3,S=4, pulse_en at t0 -> glitch_o high t0+4..5, t0+10..11, t0+16..17; done_o t0+18.
//  2. L=5,D=0,W=1,N=1, reset_en at t0 -> target_rst_o t0+1..t0+5; glitch_o t0+6; done_o t0+7.
//  3. trigger_i high before arm_i -> no run. Then low->high sampled at E0 (D=2,W=1,N=1) ->
//     glitch_o at E0+TRIG_SYNC_STAGES+3; armed_o low from E0+TRIG_SYNC_STAGES+1.
//  4. N=0 (or W=0), D=5 -> glitch_o never high; done_o at t0+6; busy_o t0+1..t0+6.
//  5. Config changed and pulse_en/arm re-strobed mid-run -> waveform per snapshot, strobes ignored.
//     rst during PULSE -> glitch_o=0 and busy_o=0 after the next edge.
//  6. reset_en and pulse_en both high at t0 -> reset path taken. arm_i in ARMED -> IDLE,
//     armed_o=0, and a later trigger edge produces no run.

Source files
------------

// File: rtl/glitcher_pkg.sv
// Shared widths and FSM state encoding for the glitch sequencer.
package glitcher_pkg;
  localparam int unsigned DELAY_W   = 16;
  localparam int unsigned WIDTH_W   = 8;
  localparam int unsigned NPULSE_W  = 8;
  localparam int unsigned SPACING_W = 16;
  localparam int unsigned RSTLEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RESET,
    ST_DELAY,
    ST_PULSE,
    ST_SPACE
  } state_e;
endpackage

// File: rtl/glitch_sequencer_if.sv
// Configuration, strobe, trigger and status signals between command handler and sequencer.
interface glitch_sequencer_if;
  import glitcher_pkg::*;

  logic [DELAY_W-1:0]   delay_i;
  logic [WIDTH_W-1:0]   width_i;
  logic [NPULSE_W-1:0]  num_pulses_i;
  logic [SPACING_W-1:0] pulse_spacing_i;
  logic [RSTLEN_W-1:0]  reset_length_i;
  logic                 pulse_en_i;
  logic                 reset_en_i;
  logic                 arm_i;
  logic                 trigger_i;
  logic                 glitch_o;
  logic                 target_rst_o;
  logic                 armed_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output delay_i, width_i, num_pulses_i, pulse_spacing_i, reset_length_i,
    output pulse_en_i, reset_en_i, arm_i, trigger_i,
    input  glitch_o, target_rst_o, armed_o, busy_o, done_o
  );

  modport slave (
    input  delay_i, width_i, num_pulses_i, pulse_spacing_i, reset_length_i,
    input  pulse_en_i, reset_en_i, arm_i, trigger_i,
    output glitch_o, target_rst_o, armed_o, busy_o, done_o
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-cycle edge pulse.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned RISING = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              in_act;

  // Falling-edge mode inverts up front so reset-to-zero is always the inactive level.
  assign in_act = (RISING != 0) ? async_i : ~async_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_act};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign edge_o = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/glitch_sequencer.sv
// Run sequencer: optional target-reset phase, delay, then N glitch pulses of width W spaced S.
module glitch_sequencer
  import glitcher_pkg::*;
#(
  parameter int unsigned TRIG_SYNC_STAGES = 2,
  parameter int unsigned TRIG_RISING      = 1
) (
  input  logic               clk,
  input  logic               rst,
  glitch_sequencer_if.slave  bus
);
  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   cnt_q, cnt_d;
  logic [NPULSE_W-1:0]  pcnt_q, pcnt_d;
  logic                 done_d, go_delay, go_pulse, trig_edge, sel_in;
  logic [DELAY_W-1:0]   dly_q, dly_c;
  logic [WIDTH_W-1:0]   wid_q, wid_c;
  logic [NPULSE_W-1:0]  np_q, np_c;
  logic [SPACING_W-1:0] sp_q, sp_c;
  logic [RSTLEN_W-1:0]  rl_q, rl_c;
  logic glitch_q, trst_q, armed_q, busy_q, done_q;
  logic glitch_d, trst_d, armed_d, busy_d;

  sync_edge_detect #(.STAGES(TRIG_SYNC_STAGES), .RISING(TRIG_RISING)) u_trig (
    .clk(clk), .rst(rst), .async_i(bus.trigger_i), .edge_o(trig_edge)
  );

  // Snapshot tracks the inputs while waiting, so it holds the start-cycle values once a run begins.
  assign sel_in = (state_q == ST_IDLE) || (state_q == ST_ARMED);
  assign dly_c  = sel_in ? bus.delay_i         : dly_q;
  assign wid_c  = sel_in ? bus.width_i         : wid_q;
  assign np_c   = sel_in ? bus.num_pulses_i    : np_q;
  assign sp_c   = sel_in ? bus.pulse_spacing_i : sp_q;
  assign rl_c   = sel_in ? bus.reset_length_i  : rl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '0; wid_q <= '0; np_q <= '0; sp_q <= '0; rl_q <= '0;
    end else if (sel_in) begin
      dly_q <= bus.delay_i;        wid_q <= bus.width_i;
      np_q  <= bus.num_pulses_i;   sp_q  <= bus.pulse_spacing_i;
      rl_q  <= bus.reset_length_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE; cnt_q <= '0; pcnt_q <= '0;
      glitch_q <= 1'b0; trst_q <= 1'b0; armed_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; pcnt_q <= pcnt_d;
      glitch_q <= glitch_d; trst_q <= trst_d; armed_q <= armed_d; busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Zero-length phases are skipped by chaining go_delay -> go_pulse within one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    done_d   = 1'b0;
    go_delay = 1'b0;
    go_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.reset_en_i && (rl_c != '0)) begin
          state_d = ST_RESET;
          cnt_d   = rl_c - 16'd1;
        end else if (bus.reset_en_i || bus.pulse_en_i) begin
          go_delay = 1'b1;
        end else if (bus.arm_i) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (trig_edge)      go_delay = 1'b1;
        else if (bus.arm_i) state_d  = ST_IDLE;
      end
      ST_RESET: begin
        if (cnt_q == '0) go_delay = 1'b1;
        else             cnt_d    = cnt_q - 16'd1;
      end
      ST_DELAY: begin
        if (cnt_q == '0) go_pulse = 1'b1;
        else             cnt_d    = cnt_q - 16'd1;
      end
      ST_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (pcnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          pcnt_d = pcnt_q - 8'd1;
          if (sp_c != '0) begin
            state_d = ST_SPACE;
            cnt_d   = sp_c - 16'd1;
          end else begin
            cnt_d = {8'd0, wid_c} - 16'd1;
          end
        end
      end
      ST_SPACE: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = {8'd0, wid_c} - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_delay) begin
      if (dly_c != '0) begin
        state_d = ST_DELAY;
        cnt_d   = dly_c - 16'd1;
      end else begin
        go_pulse = 1'b1;
      end
    end
    if (go_pulse) begin
      if ((wid_c != '0) && (np_c != '0)) begin
        state_d = ST_PULSE;
        cnt_d   = {8'd0, wid_c} - 16'd1;
        pcnt_d  = np_c - 8'd1;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // Outputs decode the next state so the registered pins line up with the state they describe.
  always_comb begin
    glitch_d = (state_d == ST_PULSE);
    trst_d   = (state_d == ST_RESET);
    armed_d  = (state_d == ST_ARMED);
    busy_d   = (state_d != ST_IDLE) || done_d;
  end

  assign bus.glitch_o     = glitch_q;
  assign bus.target_rst_o = trst_q;
  assign bus.armed_o      = armed_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench: runs are queued with their start cycle; a monitor compares every cycle.
module tb_glitch_sequencer;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  bit   mon_hold = 1'b1;

  typedef struct { int t0; int L; int D; int W; int N; int S; } run_t;
  run_t q[$];

  glitch_sequencer_if gif ();

  glitch_sequencer #(.TRIG_SYNC_STAGES(SYNC), .TRIG_RISING(1)) dut (
    .clk(clk), .rst(rst), .bus(gif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
  endtask

  // Offset k counts cycles after the start edge: k=1 is the first cycle after it.
  function automatic int done_off(input run_t r);
    int base = 1 + r.L + r.D;
    if (r.W == 0 || r.N == 0) return base;
    return base + r.N * r.W + (r.N - 1) * r.S;
  endfunction

  function automatic bit glitch_at(input run_t r, input int k);
    int base = 1 + r.L + r.D;
    int j, p;
    if (r.W == 0 || r.N == 0 || k < base) return 1'b0;
    j = k - base;
    p = r.W + r.S;
    return ((j / p) < r.N) && ((j % p) < r.W);
  endfunction

  run_t mr;
  int   mk, mdk;
  bit   eg, er, ed, act;
  always @(negedge clk) begin
    if (!mon_hold && !rst) begin
      eg = 0; er = 0; ed = 0; act = 0; mk = 0; mdk = 0;
      if (q.size() != 0) begin
        mr  = q[0];
        mk  = cyc - mr.t0 + 1;
        mdk = done_off(mr);
        if (mk >= 1) begin
          act = 1;
          er  = (mk <= mr.L);
          ed  = (mk == mdk);
          eg  = glitch_at(mr, mk);
        end
      end
      chk("glitch_o", int'(gif.glitch_o), int'(eg));
      chk("target_rst_o", int'(gif.target_rst_o), int'(er));
      chk("done_o", int'(gif.done_o), int'(ed));
      if (act) chk("busy_o_run", int'(gif.busy_o), 1);
      if (act && mk == mdk) void'(q.pop_front());
    end
  end

  task automatic set_cfg(input int l, input int d, input int w, input int n, input int s);
    gif.reset_length_i  = 16'(l);
    gif.delay_i         = 16'(d);
    gif.width_i         = 8'(w);
    gif.num_pulses_i    = 8'(n);
    gif.pulse_spacing_i = 16'(s);
  endtask

  // mode: 0 pulse_en, 1 reset_en, 2 both strobes, 3 arm + trigger edge
  task automatic launch(input int l, input int d, input int w, input int n, input int s,
                        input int mode);
    run_t r;
    set_cfg(l, d, w, n, s);
    if (mode == 3) begin
      @(negedge clk); gif.arm_i = 1'b1;
      @(negedge clk); gif.arm_i = 1'b0;
      repeat (2) @(negedge clk);
      gif.trigger_i = 1'b1;
      r.t0 = cyc + 1 + SYNC;
    end else begin
      @(negedge clk);
      gif.pulse_en_i = (mode != 1);
      gif.reset_en_i = (mode != 0);
      r.t0 = cyc + 1;
    end
    r.L = (mode == 1 || mode == 2) ? l : 0;
    r.D = d; r.W = w; r.N = n; r.S = s;
    q.push_back(r);
    if (mode != 3) begin
      @(negedge clk);
      gif.pulse_en_i = 1'b0;
      gif.reset_en_i = 1'b0;
    end
  endtask

  task automatic disturb();
    run_t r;
    int n = 0;
    int v;
    if (q.size() == 0) return;
    r = q[q.size() - 1];
    while (cyc < r.t0 && n < 50) begin @(negedge clk); n++; end
    if ((cyc - r.t0 + 2) < done_off(r)) begin
      v = int'($urandom_range(1, 7));
      gif.pulse_en_i = v[0]; gif.reset_en_i = v[1]; gif.arm_i = v[2];
      set_cfg(int'($urandom_range(1, 9)), int'($urandom_range(0, 9)),
              int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), int'($urandom_range(0, 9)));
      @(negedge clk);
      gif.pulse_en_i = 1'b0; gif.reset_en_i = 1'b0; gif.arm_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("run_timeout", q.size(), 0);
      q.delete();
    end
    gif.trigger_i = 1'b0;
    @(negedge clk);
    chk("busy_o_idle", int'(gif.busy_o), 0);
    chk("armed_o_idle", int'(gif.armed_o), 0);
  endtask

  initial begin
    int mode, l;
    set_cfg(0, 0, 0, 0, 0);
    gif.pulse_en_i = 1'b0; gif.reset_en_i = 1'b0; gif.arm_i = 1'b0; gif.trigger_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_glitch_o", int'(gif.glitch_o), 0);
    chk("rst_target_rst_o", int'(gif.target_rst_o), 0);
    chk("rst_armed_o", int'(gif.armed_o), 0);
    chk("rst_busy_o", int'(gif.busy_o), 0);
    chk("rst_done_o", int'(gif.done_o), 0);
    rst = 1'b0;
    @(negedge clk);
    mon_hold = 1'b0;

    launch(0, 3, 2, 3, 4, 0); wait_idle(200);
    launch(5, 0, 1, 1, 0, 1); wait_idle(200);
    launch(0, 5, 1, 0, 2, 0); wait_idle(200);
    launch(0, 5, 0, 3, 2, 0); wait_idle(200);
    launch(3, 2, 2, 2, 1, 2); wait_idle(200);
    launch(0, 2, 1, 1, 0, 1); wait_idle(200);
    launch(0, 0, 0, 0, 0, 0); wait_idle(200);
    launch(0, 1, 2, 3, 0, 0); wait_idle(200);

    // trigger level present before arming must not start a run
    set_cfg(0, 2, 1, 1, 0);
    gif.trigger_i = 1'b1;
    repeat (4) @(negedge clk);
    gif.arm_i = 1'b1; @(negedge clk); gif.arm_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("armed_o_level", int'(gif.armed_o), 1);
    gif.trigger_i = 1'b0;
    repeat (4) @(negedge clk);
    gif.trigger_i = 1'b1;
    begin
      run_t r;
      r.t0 = cyc + 1 + SYNC; r.L = 0; r.D = 2; r.W = 1; r.N = 1; r.S = 0;
      q.push_back(r);
    end
    @(negedge clk); @(negedge clk);
    chk("armed_o_before_start", int'(gif.armed_o), 1);
    @(negedge clk);
    chk("armed_o_after_start", int'(gif.armed_o), 0);
    wait_idle(200);

    launch(0, 2, 3, 3, 2, 0); disturb(); wait_idle(200);
    launch(4, 1, 2, 2, 3, 1); disturb(); wait_idle(200);

    // reset in the middle of a long pulse
    launch(0, 2, 50, 1, 0, 0);
    repeat (8) @(negedge clk);
    mon_hold = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_glitch_o", int'(gif.glitch_o), 0);
    chk("midrst_busy_o", int'(gif.busy_o), 0);
    chk("midrst_target_rst_o", int'(gif.target_rst_o), 0);
    q.delete();
    rst = 1'b0;
    @(negedge clk);
    mon_hold = 1'b0;

    // disarm, then a trigger edge must do nothing
    gif.arm_i = 1'b1; @(negedge clk); gif.arm_i = 1'b0;
    @(negedge clk);
    chk("armed_o_arm", int'(gif.armed_o), 1);
    gif.arm_i = 1'b1; @(negedge clk); gif.arm_i = 1'b0;
    @(negedge clk);
    chk("armed_o_disarm", int'(gif.armed_o), 0);
    gif.trigger_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_o_disarmed_trig", int'(gif.busy_o), 0);
    wait_idle(10);

    launch(0, 0, 255, 1, 0, 0);   wait_idle(400);
    launch(0, 0, 1, 255, 0, 0);   wait_idle(400);
    launch(0, 0, 1, 255, 1, 0);   wait_idle(700);
    launch(0, 65535, 1, 1, 0, 0); wait_idle(70000);

    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 3));
      l    = int'($urandom_range(0, 6));
      launch(l, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), mode);
      if ($urandom_range(0, 1) == 1) disturb();
      wait_idle(400);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
